// File: rtl/shift_tap_ctrl.sv
// Write/read sequencer for the line-buffer bank: line addressing, rotating RAM pointer,
// valid-line mask, overflow flag, and sync/de delay pipes aligned with the tap data.
//
// state      | meaning
// WAIT_FRAME | no frame seen since reset; pixels are ignored
// BLANK      | inside a frame, between lines
// ACTIVE     | writing pixels of the current line
module shift_tap_ctrl #(
   parameter int COL    = 2,
   parameter int DSIZE  = 10,
   parameter int ASIZE  = 10,
   parameter int RD_LAT = 2
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             in_vs,
   input  logic             in_de,
   input  logic [DSIZE-1:0] in_data,
   output logic             wr_en,
   output logic [ASIZE-1:0] wr_addr,
   output logic [DSIZE-1:0] wr_data,
   output logic             rd_en,
   output logic [ASIZE-1:0] rd_addr,
   output logic [COL-1:0]   rd_mask,
   output logic [3:0]       wr_point,
   output logic [3:0]       rd_point,
   output logic             out_vs,
   output logic             out_de,
   output logic             ovf
);

   localparam int LW = $clog2(COL + 1);
   localparam logic [ASIZE-1:0] ADDR_MAX = '1;

   typedef enum logic [1:0] {WAIT_FRAME, BLANK, ACTIVE} state_t;

   state_t          state;
   logic            vs_q;
   logic            vs_rise;
   logic [LW-1:0]   line_cnt;
   logic [LW-1:0]   line_cnt_nxt;
   logic [RD_LAT:0] vs_pipe;
   logic [RD_LAT:0] de_pipe;

   function automatic logic [COL-1:0] fill_mask(input logic [LW-1:0] n);
      fill_mask = '0;
      for (int k = 0; k < COL; k++)
         fill_mask[k] = (k < int'(n));
   endfunction

   assign vs_rise      = in_vs & ~vs_q;
   assign line_cnt_nxt = (line_cnt == LW'(COL)) ? line_cnt : line_cnt + 1'b1;

   // ram_list sees the same address/pointer on both ports; only the mask differs in meaning
   assign rd_en    = wr_en;
   assign rd_addr  = wr_addr;
   assign rd_point = wr_point;
   assign out_vs   = vs_pipe[RD_LAT];
   assign out_de   = de_pipe[RD_LAT];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_FRAME;
         vs_q     <= 1'b0;
         vs_pipe  <= '0;
         de_pipe  <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         wr_point <= '0;
         line_cnt <= '0;
         rd_mask  <= '0;
         ovf      <= 1'b0;
      end else begin
         vs_q    <= in_vs;
         vs_pipe <= {vs_pipe[RD_LAT-1:0], in_vs};
         de_pipe <= {de_pipe[RD_LAT-1:0], in_de};

         if (vs_rise) begin
            // a line cut off by frame start is dropped without advancing the pointer
            state    <= BLANK;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_point <= '0;
            line_cnt <= '0;
            rd_mask  <= '0;
            ovf      <= 1'b0;
         end else begin
            case (state)
               WAIT_FRAME: begin
                  wr_en <= 1'b0;
               end
               BLANK: begin
                  if (in_de) begin
                     wr_en   <= 1'b1;
                     wr_addr <= '0;
                     wr_data <= in_data;
                     state   <= ACTIVE;
                  end else begin
                     wr_en <= 1'b0;
                  end
               end
               ACTIVE: begin
                  if (in_de) begin
                     if (wr_addr == ADDR_MAX) begin
                        wr_en <= 1'b0;
                        ovf   <= 1'b1;
                     end else begin
                        wr_en   <= 1'b1;
                        wr_addr <= wr_addr + 1'b1;
                        wr_data <= in_data;
                     end
                  end else begin
                     wr_en    <= 1'b0;
                     state    <= BLANK;
                     wr_point <= (wr_point == 4'(COL - 1)) ? 4'd0 : wr_point + 4'd1;
                     line_cnt <= line_cnt_nxt;
                     rd_mask  <= fill_mask(line_cnt_nxt);
                  end
               end
               default: begin
                  wr_en <= 1'b0;
                  state <= WAIT_FRAME;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_shift_tap_ctrl.sv
// Directed bench for shift_tap_ctrl with COL=3, ASIZE=4, RD_LAT=2.
module tb_shift_tap_ctrl;

   localparam int COL    = 3;
   localparam int DSIZE  = 8;
   localparam int ASIZE  = 4;
   localparam int RD_LAT = 2;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             in_vs;
   logic             in_de;
   logic [DSIZE-1:0] in_data;
   logic             wr_en;
   logic [ASIZE-1:0] wr_addr;
   logic [DSIZE-1:0] wr_data;
   logic             rd_en;
   logic [ASIZE-1:0] rd_addr;
   logic [COL-1:0]   rd_mask;
   logic [3:0]       wr_point;
   logic [3:0]       rd_point;
   logic             out_vs;
   logic             out_de;
   logic             ovf;

   int total = 0;
   int bad   = 0;

   shift_tap_ctrl #(.COL(COL), .DSIZE(DSIZE), .ASIZE(ASIZE), .RD_LAT(RD_LAT)) dut (
      .clock(clock), .rst_n(rst_n), .in_vs(in_vs), .in_de(in_de), .in_data(in_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_mask(rd_mask), .wr_point(wr_point), .rd_point(rd_point), .out_vs(out_vs),
      .out_de(out_de), .ovf(ovf)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic       vs;
      logic       de;
      logic [7:0] d;
      logic       en;
      logic [3:0] addr;
      logic [7:0] data;
      logic [3:0] pt;
      logic [2:0] mask;
   } vec_t;

   vec_t tbl[8];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic vs, input logic de, input logic [7:0] d);
      in_vs   = vs;
      in_de   = de;
      in_data = d;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   function automatic int mask_of(input int n);
      return (1 << n) - 1;
   endfunction

   function automatic int min3(input int n);
      return (n > COL) ? COL : n;
   endfunction

   task automatic do_line(input int npix, input int base, input int ptr, input int msk,
                          input int ptr_after, input int msk_after);
      for (int i = 0; i < npix; i++) begin
         drive(1'b0, 1'b1, 8'(base + i));
         tick();
         chk("line_en", 32'(wr_en), 32'd1);
         chk("line_addr", 32'(wr_addr), 32'(i));
         chk("line_rd_addr", 32'(rd_addr), 32'(i));
         chk("line_data", 32'(wr_data), 32'(base + i));
         chk("line_point", 32'(wr_point), 32'(ptr));
         chk("line_mask", 32'(rd_mask), 32'(msk));
      end
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("eol_en", 32'(wr_en), 32'd0);
      chk("eol_point", 32'(wr_point), 32'(ptr_after));
      chk("eol_rd_point", 32'(rd_point), 32'(ptr_after));
      chk("eol_mask", 32'(rd_mask), 32'(msk_after));
      repeat (3) tick();
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 4'd0, 3'b000};
      tbl[1] = '{1'b0, 1'b1, 8'h11, 1'b1, 4'd0, 8'h11, 4'd0, 3'b000};
      tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h11, 4'd1, 3'b001};
      tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 8'h11, 4'd1, 3'b001};
      tbl[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 4'd0, 8'h22, 4'd1, 3'b001};
      tbl[5] = '{1'b0, 1'b1, 8'h23, 1'b1, 4'd1, 8'h23, 4'd1, 3'b001};
      tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 8'h23, 4'd2, 3'b011};
      tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd1, 8'h23, 4'd2, 3'b011};

      rst_n = 1'b0;
      drive(1'b0, 1'b0, 8'h00);
      tick();
      tick();
      chk("reset_all", 32'({wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_mask, wr_point,
                            rd_point, out_vs, out_de, ovf}), 32'd0);
      rst_n = 1'b1;

      // pixels before any vsync are ignored
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, 1'b1, 8'h55);
         tick();
         chk("novs_en", 32'(wr_en), 32'd0);
         chk("novs_regs", 32'({wr_addr, wr_data, rd_mask, wr_point, ovf}), 32'd0);
      end
      drive(1'b0, 1'b0, 8'h00);
      tick();

      for (int i = 0; i < 8; i++) begin
         drive(tbl[i].vs, tbl[i].de, tbl[i].d);
         tick();
         chk($sformatf("tbl%0d_en", i), 32'(wr_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_rd_en", i), 32'(rd_en), 32'(tbl[i].en));
         chk($sformatf("tbl%0d_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
         chk($sformatf("tbl%0d_data", i), 32'(wr_data), 32'(tbl[i].data));
         chk($sformatf("tbl%0d_point", i), 32'(wr_point), 32'(tbl[i].pt));
         chk($sformatf("tbl%0d_mask", i), 32'(rd_mask), 32'(tbl[i].mask));
      end

      // delay pipes: 1+RD_LAT = 3 cycles
      repeat (4) tick();
      drive(1'b1, 1'b0, 8'h00);
      tick();
      chk("dly_vs1", 32'(out_vs), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("dly_vs2", 32'(out_vs), 32'd0);
      tick();
      chk("dly_vs3", 32'(out_vs), 32'd1);
      tick();
      chk("dly_vs4", 32'(out_vs), 32'd0);
      drive(1'b0, 1'b1, 8'h77);
      tick();
      chk("pulse_en", 32'(wr_en), 32'd1);
      chk("dly_de1", 32'(out_de), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("pulse_point", 32'(wr_point), 32'd1);
      chk("pulse_mask", 32'(rd_mask), 32'b001);
      chk("dly_de2", 32'(out_de), 32'd0);
      tick();
      chk("dly_de3", 32'(out_de), 32'd1);
      tick();
      chk("dly_de4", 32'(out_de), 32'd0);

      // five 8-pixel lines: pointer rotation and mask saturation
      drive(1'b1, 1'b0, 8'h00);
      tick();
      chk("f5_point", 32'(wr_point), 32'd0);
      chk("f5_mask", 32'(rd_mask), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      repeat (2) tick();
      for (int l = 0; l < 5; l++)
         do_line(8, l * 16, l % COL, mask_of(min3(l)), (l + 1) % COL, mask_of(min3(l + 1)));

      // vsync in the middle of line 2
      drive(1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b0, 1'b0, 8'h00);
      tick();
      do_line(8, 0, 0, 0, 1, 1);
      do_line(8, 16, 1, 1, 2, 3);
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 8'(32 + i));
         tick();
      end
      chk("mid_pre_point", 32'(wr_point), 32'd2);
      drive(1'b1, 1'b1, 8'h24);
      tick();
      chk("mid_vs_point", 32'(wr_point), 32'd0);
      chk("mid_vs_mask", 32'(rd_mask), 32'd0);
      chk("mid_vs_en", 32'(wr_en), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("mid_after_point", 32'(wr_point), 32'd0);
      tick();
      do_line(8, 48, 0, 0, 1, 1);

      // 20-pixel line overflows a 16-entry line
      drive(1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b0, 1'b0, 8'h00);
      tick();
      for (int i = 0; i < 20; i++) begin
         drive(1'b0, 1'b1, 8'(i));
         tick();
         chk($sformatf("ovf_en%0d", i), 32'(wr_en), 32'(i < 16));
         chk($sformatf("ovf_addr%0d", i), 32'(wr_addr), 32'((i > 15) ? 15 : i));
         chk($sformatf("ovf_flag%0d", i), 32'(ovf), 32'(i >= 16));
      end
      drive(1'b0, 1'b0, 8'h00);
      tick();
      chk("ovf_eol_point", 32'(wr_point), 32'd1);
      chk("ovf_eol_mask", 32'(rd_mask), 32'b001);
      repeat (2) tick();
      chk("ovf_sticky", 32'(ovf), 32'd1);
      drive(1'b1, 1'b0, 8'h00);
      tick();
      chk("ovf_clear", 32'(ovf), 32'd0);
      drive(1'b0, 1'b0, 8'h00);
      tick();

      // asynchronous reset in the middle of a line
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'(i + 1));
         tick();
      end
      chk("rstmid_pre_en", 32'(wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rstmid_async", 32'({wr_en, wr_addr, wr_data, rd_mask, wr_point, ovf}), 32'd0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 8'h09);
         tick();
         chk("rstmid_novs_en", 32'(wr_en), 32'd0);
      end
      drive(1'b1, 1'b0, 8'h00);
      tick();
      drive(1'b0, 1'b1, 8'h3c);
      tick();
      chk("rstmid_resume_en", 32'(wr_en), 32'd1);
      chk("rstmid_resume_addr", 32'(wr_addr), 32'd0);
      chk("rstmid_resume_data", 32'(wr_data), 32'h3c);
      drive(1'b0, 1'b0, 8'h00);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
